mpsoc_wb_uart_transmitter: RTL and testbench

- Transmit path of the Wishbone UART core: the outbound counterpart of the receive-side input synchronizer.
- Buffers bytes written by the register block in a FIFO and serializes each as an asynchronous frame on the serial output pin.
- Frame format: start, 5–8 data bits LSB first, optional parity, 1/1.5/2 stop bits.
- Bit timing is driven by the 16x baud enable strobe from the divisor logic.

---
 rtl/mpsoc_wb_uart_transmitter.sv | 183 ++++++++++++++++++
 tb/tb_mpsoc_wb_uart_transmitter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mpsoc_wb_uart_transmitter.sv
// Wishbone UART transmit path: byte FIFO feeding an async-frame serializer clocked by the 16x baud strobe.
// Optional UART_TX_BREAK_EN: lcr_i[6] forces the serial line low while set.
module mpsoc_wb_uart_transmitter #(
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               enable_i,
    input  logic [7:0]         lcr_i,
    input  logic [7:0]         tx_dat_i,
    input  logic               tx_push_i,
    input  logic               tx_fifo_rst_i,
    output logic               stx_o,
    output logic [FIFO_AW:0]   tx_count_o,
    output logic               tx_full_o,
    output logic               thre_o,
    output logic               temt_o
);
    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state_reg, state_next;
    logic [3:0]           tick_reg, tick_next;
    logic [2:0]           bit_reg, bit_next;
    logic [7:0]           shift_reg, shift_next;
    logic                 par_reg, par_next;
    logic [7:0]           mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [FIFO_AW:0]     count_reg, count_next;
    logic                 stx_reg, thre_reg, temt_reg;
    logic                 stx_next, stx_line;
    logic                 pop, push_ok, fifo_empty, parity_bit;
    logic [2:0]           last_bit;
    logic [4:0]           stop_last;
    logic [7:0]           data_mask;
    logic [7:0]           head;

    assign fifo_empty = (count_reg == '0);
    assign push_ok    = tx_push_i && ((count_reg != DEPTH_C) || pop);
    assign count_next = count_reg + {{FIFO_AW{1'b0}}, push_ok} - {{FIFO_AW{1'b0}}, pop};
    assign head       = mem[rd_ptr_reg];
    assign last_bit   = 3'd4 + {1'b0, lcr_i[1:0]};
    // STOP length minus one, counted over {bit_reg[0], tick_reg}
    assign stop_last  = !lcr_i[2] ? 5'd15 : ((lcr_i[1:0] == 2'b00) ? 5'd23 : 5'd31);
    assign parity_bit = lcr_i[5] ? ~lcr_i[4] : (lcr_i[4] ? par_reg : ~par_reg);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_mask
            assign data_mask[gi] = (3'(gi) <= last_bit);
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        tick_next  = tick_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        par_next   = par_reg;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (enable_i && !fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = head;
                    par_next   = ^(head & data_mask);
                    tick_next  = 4'd0;
                    bit_next   = 3'd0;
                    state_next = START;
                end
            end
            START: begin
                if (enable_i) begin
                    tick_next = tick_reg + 4'd1;
                    if (tick_reg == 4'd15) begin
                        bit_next   = 3'd0;
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (enable_i) begin
                    tick_next = tick_reg + 4'd1;
                    if (tick_reg == 4'd15) begin
                        shift_next = {1'b0, shift_reg[7:1]};
                        // >= keeps the FSM moving if word length shrinks mid-frame
                        if (bit_reg >= last_bit) begin
                            bit_next   = 3'd0;
                            state_next = lcr_i[3] ? PARITY : STOP;
                        end else begin
                            bit_next = bit_reg + 3'd1;
                        end
                    end
                end
            end
            PARITY: begin
                if (enable_i) begin
                    tick_next = tick_reg + 4'd1;
                    if (tick_reg == 4'd15) begin
                        bit_next   = 3'd0;
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (enable_i) begin
                    tick_next = tick_reg + 4'd1;
                    if (tick_reg == 4'd15)
                        bit_next = bit_reg + 3'd1;
                    if ({bit_reg[0], tick_reg} >= stop_last) begin
                        tick_next  = 4'd0;
                        bit_next   = 3'd0;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        stx_next = 1'b1;
        case (state_next)
            START:   stx_next = 1'b0;
            DATA:    stx_next = shift_next[0];
            PARITY:  stx_next = parity_bit;
            default: stx_next = 1'b1;
        endcase
    end

`ifdef UART_TX_BREAK_EN
    assign stx_line = lcr_i[6] ? 1'b0 : stx_next;
    logic unused_lcr;
    assign unused_lcr = lcr_i[7];
`else
    assign stx_line = stx_next;
    logic unused_lcr;
    assign unused_lcr = ^lcr_i[7:6];
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i || tx_fifo_rst_i) begin
            state_reg  <= IDLE;
            tick_reg   <= 4'd0;
            bit_reg    <= 3'd0;
            shift_reg  <= 8'd0;
            par_reg    <= 1'b0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            stx_reg    <= 1'b1;
            thre_reg   <= 1'b1;
            temt_reg   <= 1'b1;
        end else begin
            state_reg  <= state_next;
            tick_reg   <= tick_next;
            bit_reg    <= bit_next;
            shift_reg  <= shift_next;
            par_reg    <= par_next;
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + FIFO_AW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + FIFO_AW'(1);
            count_reg  <= count_next;
            stx_reg    <= stx_line;
            thre_reg   <= (count_next == '0);
            temt_reg   <= (count_next == '0) && (state_next == IDLE);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !rst_i && !tx_fifo_rst_i)
            mem[wr_ptr_reg] <= tx_dat_i;
    end

    assign stx_o      = stx_reg;
    assign tx_count_o = count_reg;
    assign tx_full_o  = (count_reg == DEPTH_C);
    assign thre_o     = thre_reg;
    assign temt_o     = temt_reg;
endmodule

// File: tb/tb_mpsoc_wb_uart_transmitter.sv
// Self-checking bench for the UART transmitter: per-tick expected line levels built from frame rules.
module tb_mpsoc_wb_uart_transmitter;
    logic       clk_i = 1'b0;
    logic       rst_i, enable_i, tx_push_i, tx_fifo_rst_i;
    logic [7:0] lcr_i, tx_dat_i;
    logic       stx_o, tx_full_o, thre_o, temt_o;
    logic [4:0] tx_count_o;

    int vectors = 0;
    int miscompares = 0;

    logic       exp_stx_q[$];
    int         exp_cnt_q[$];
    logic       exp_thre_q[$];
    logic       exp_temt_q[$];
    logic [7:0] data_q[$];

    always #5 clk_i = ~clk_i;

    mpsoc_wb_uart_transmitter #(.FIFO_DEPTH(16), .FIFO_AW(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .lcr_i(lcr_i),
        .tx_dat_i(tx_dat_i), .tx_push_i(tx_push_i), .tx_fifo_rst_i(tx_fifo_rst_i),
        .stx_o(stx_o), .tx_count_o(tx_count_o), .tx_full_o(tx_full_o),
        .thre_o(thre_o), .temt_o(temt_o)
    );

    // Expand every queued byte into one expected line level per enable tick
    task automatic build(input logic [7:0] lcr);
        int n, stop_len, m, rem;
        logic xr, par;
        logic [7:0] d;
        logic lv[$];
        m = data_q.size();
        n = 5 + int'(lcr[1:0]);
        stop_len = !lcr[2] ? 16 : ((n == 5) ? 24 : 32);
        for (int j = 0; j < m; j++) begin
            d = data_q[j];
            rem = m - 1 - j;
            lv.delete();
            xr = 1'b0;
            for (int t = 0; t < 16; t++) lv.push_back(1'b0);
            for (int i = 0; i < n; i++) begin
                xr = xr ^ d[i];
                for (int t = 0; t < 16; t++) lv.push_back(d[i]);
            end
            if (lcr[3]) begin
                par = lcr[5] ? ~lcr[4] : (lcr[4] ? xr : ~xr);
                for (int t = 0; t < 16; t++) lv.push_back(par);
            end
            for (int t = 0; t < stop_len; t++) lv.push_back(1'b1);
            lv.push_back(1'b1);
            for (int k = 0; k < lv.size(); k++) begin
                exp_stx_q.push_back(lv[k]);
                exp_cnt_q.push_back(rem);
                exp_thre_q.push_back(rem == 0);
                exp_temt_q.push_back((rem == 0) && (k == lv.size() - 1));
            end
            $display("frame queued: lcr=%02h data=%02h ticks=%0d", lcr, d, lv.size() - 1);
        end
        data_q.delete();
    endtask

    task automatic push_byte(input logic [7:0] d);
        tx_dat_i  = d;
        tx_push_i = 1'b1;
        @(posedge clk_i); #1;
        tx_push_i = 1'b0;
    endtask

    task automatic run_edges(input int n);
        logic e_stx, e_thre, e_temt;
        int e_cnt, gap;
        for (int k = 0; k < n; k++) begin
            e_stx = 1'b1; e_cnt = 0; e_thre = 1'b1; e_temt = 1'b1;
            if (exp_stx_q.size() > 0) begin
                e_stx  = exp_stx_q.pop_front();
                e_cnt  = exp_cnt_q.pop_front();
                e_thre = exp_thre_q.pop_front();
                e_temt = exp_temt_q.pop_front();
            end
            enable_i = 1'b1;
            @(posedge clk_i); #1;
            enable_i = 1'b0;
            vectors += 5;
            if (stx_o !== e_stx) begin
                miscompares++;
                $display("FAIL stx tick=%0d got=%b exp=%b", k, stx_o, e_stx);
            end
            if (tx_count_o !== 5'(e_cnt)) begin
                miscompares++;
                $display("FAIL tx_count tick=%0d got=%0d exp=%0d", k, tx_count_o, e_cnt);
            end
            if (tx_full_o !== (e_cnt == 16)) begin
                miscompares++;
                $display("FAIL tx_full tick=%0d got=%b exp=%b", k, tx_full_o, e_cnt == 16);
            end
            if (thre_o !== e_thre) begin
                miscompares++;
                $display("FAIL thre tick=%0d got=%b exp=%b", k, thre_o, e_thre);
            end
            if (temt_o !== e_temt) begin
                miscompares++;
                $display("FAIL temt tick=%0d got=%b exp=%b", k, temt_o, e_temt);
            end
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(posedge clk_i); #1;
                vectors++;
                if (stx_o !== e_stx) begin
                    miscompares++;
                    $display("FAIL stx_hold tick=%0d got=%b exp=%b", k, stx_o, e_stx);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; enable_i = 1'b0; tx_push_i = 1'b0; tx_fifo_rst_i = 1'b0;
        lcr_i = 8'h03; tx_dat_i = 8'h00;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        vectors += 5;
        if (stx_o !== 1'b1)      begin miscompares++; $display("FAIL reset_stx got=%b exp=1", stx_o); end
        if (tx_count_o !== 5'd0) begin miscompares++; $display("FAIL reset_count got=%0d exp=0", tx_count_o); end
        if (tx_full_o !== 1'b0)  begin miscompares++; $display("FAIL reset_full got=%b exp=0", tx_full_o); end
        if (thre_o !== 1'b1)     begin miscompares++; $display("FAIL reset_thre got=%b exp=1", thre_o); end
        if (temt_o !== 1'b1)     begin miscompares++; $display("FAIL reset_temt got=%b exp=1", temt_o); end
    endtask

    task automatic send_one(input logic [7:0] lcr, input logic [7:0] d);
        lcr_i = lcr;
        push_byte(d);
        vectors++;
        if (thre_o !== 1'b0) begin miscompares++; $display("FAIL thre_after_push got=%b exp=0", thre_o); end
        data_q.push_back(d);
        build(lcr);
        run_edges(exp_stx_q.size() + 4);
    endtask

    task automatic test_frames();
        logic [7:0] lcr_tab [5] = '{8'h03, 8'h1A, 8'h0A, 8'h04, 8'h07};
        logic [7:0] dat_tab [5] = '{8'hA5, 8'h35, 8'h35, 8'h1F, 8'h1F};
        for (int i = 0; i < 5; i++) send_one(lcr_tab[i], dat_tab[i]);
        for (int i = 0; i < 6; i++) send_one(8'($urandom_range(0, 63)), 8'($urandom));
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        logic [7:0] lcr;
        lcr = 8'($urandom_range(0, 63));
        lcr_i = lcr;
        for (int i = 0; i < 17; i++) begin
            d = 8'($urandom);
            push_byte(d);
            if (i < 16) data_q.push_back(d);
        end
        vectors += 4;
        if (tx_count_o !== 5'd16) begin miscompares++; $display("FAIL full_count got=%0d exp=16", tx_count_o); end
        if (tx_full_o !== 1'b1)   begin miscompares++; $display("FAIL full_flag got=%b exp=1", tx_full_o); end
        if (thre_o !== 1'b0)      begin miscompares++; $display("FAIL full_thre got=%b exp=0", thre_o); end
        if (temt_o !== 1'b0)      begin miscompares++; $display("FAIL full_temt got=%b exp=0", temt_o); end
        build(lcr);
        run_edges(exp_stx_q.size() + 4);
    endtask

    task automatic test_abort();
        lcr_i = 8'h03;
        for (int i = 0; i < 4; i++) begin
            data_q.push_back(8'($urandom));
            push_byte(data_q[i]);
        end
        build(8'h03);
        run_edges(16 + 16 * 3 + 5);
        exp_stx_q.delete(); exp_cnt_q.delete(); exp_thre_q.delete(); exp_temt_q.delete();
        tx_fifo_rst_i = 1'b1;
        tx_push_i     = 1'b1;
        tx_dat_i      = 8'h00;
        enable_i      = 1'($urandom_range(0, 1));
        @(posedge clk_i); #1;
        tx_fifo_rst_i = 1'b0; tx_push_i = 1'b0; enable_i = 1'b0;
        vectors += 4;
        if (stx_o !== 1'b1)      begin miscompares++; $display("FAIL abort_stx got=%b exp=1", stx_o); end
        if (tx_count_o !== 5'd0) begin miscompares++; $display("FAIL abort_count got=%0d exp=0", tx_count_o); end
        if (temt_o !== 1'b1)     begin miscompares++; $display("FAIL abort_temt got=%b exp=1", temt_o); end
        if (thre_o !== 1'b1)     begin miscompares++; $display("FAIL abort_thre got=%b exp=1", thre_o); end
        run_edges(200);
    endtask

    task automatic test_break();
        logic e_brk;
`ifdef UART_TX_BREAK_EN
        e_brk = 1'b0;
`else
        e_brk = 1'b1;
`endif
        lcr_i = 8'h43;
        @(posedge clk_i); #1;
        vectors++;
        if (stx_o !== e_brk) begin miscompares++; $display("FAIL break_on got=%b exp=%b", stx_o, e_brk); end
        lcr_i = 8'h03;
        @(posedge clk_i); #1;
        vectors++;
        if (stx_o !== 1'b1) begin miscompares++; $display("FAIL break_off got=%b exp=1", stx_o); end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_back_to_back();
        test_abort();
        test_break();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
